// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 opcode constants, controller state and mux-select encodings.
package riscv_pkg;

  localparam logic [6:0] R_type  = 7'b0110011;
  localparam logic [6:0] I_type  = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] S_type  = 7'b0100011;
  localparam logic [6:0] B_type  = 7'b1100011;
  localparam logic [6:0] U_type  = 7'b0110111;
  localparam logic [6:0] OP_AUPC = 7'b0010111;
  localparam logic [6:0] J_type  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  function automatic logic op_legal(input logic [6:0] o);
    case (o)
      R_type, I_type, OP_LW, S_type, B_type, U_type, OP_AUPC, J_type, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - Memory ack wait counter with timeout compare.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  logic [15:0] count;
  logic [16:0] next_count;

  assign next_count = {1'b0, count} + 17'd1;
  // The cycle that would bring the count to the limit expires, unless ack arrives in it.
  assign expired = req && !ack && (next_count >= 17'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n || clr || ack) begin
      count <= '0;
    end else if (req) begin
      count <= next_count[15:0];
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Multi-cycle RV32 sequencing controller (fetch/decode/exec/mem/wb).
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [6:0]  imm_op,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  state_t      state_q, state_d;
  logic        started;
  logic [6:0]  imm_op_q;
  logic        illegal_q, timeout_q;
  logic [31:0] instret_q;
  logic        retire, set_illegal, expired;
  logic        wait_req, wait_ack, wait_clr;

  // started keeps requests low until rst_n has been sampled high once.
  assign wait_req = started && (state_q == FETCH || state_q == MEM);
  assign wait_ack = started && ((state_q == FETCH && imem_ack) || (state_q == MEM && dmem_ack));
  assign wait_clr = !(state_q == FETCH || state_q == MEM);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .req     (wait_req),
    .ack     (wait_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      started   <= 1'b0;
      imm_op_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      started <= 1'b1;
      if (state_q == DECODE) imm_op_q <= op;
      if (set_illegal) illegal_q <= 1'b1;
      if (expired) timeout_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      FETCH: begin
        if (started) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end else if (expired) begin
            state_d = TRAP;
          end
        end
      end
      DECODE: begin
        if (!op_legal(op)) begin
          set_illegal = 1'b1;
          state_d     = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a_sel = (imm_op_q == OP_AUPC) || (imm_op_q == J_type) || (imm_op_q == B_type);
        alu_b_sel = !((imm_op_q == R_type) || (imm_op_q == B_type));
        if (imm_op_q == B_type) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (imm_op_q == OP_LW || imm_op_q == S_type) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (imm_op_q == S_type);
        if (dmem_ack) begin
          if (imm_op_q == S_type) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (expired) begin
          state_d = TRAP;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
        if (imm_op_q == OP_LW) wb_sel = WB_LOAD;
        else if (imm_op_q == J_type || imm_op_q == OP_JALR) wb_sel = WB_PC4;
        if (imm_op_q == J_type) pc_sel = PC_IMM;
        else if (imm_op_q == OP_JALR) pc_sel = PC_ALU;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign imm_op  = imm_op_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - Self-checking bench for multicycle_ctrl with MEM_TIMEOUT=4.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_sel, wb_sel;
  logic        alu_a_sel, alu_b_sel, rf_we, illegal, timeout;
  logic [6:0]  imm_op;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .imm_op(imm_op), .illegal(illegal),
    .timeout(timeout), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 0;

  typedef struct {
    logic [6:0] op; logic br; int iw; int dw;
    int cyc; int rf; int wb; int pcs; int a; int b;
  } vec_t;

  typedef struct {int cyc; int rf; int wb; int pcs; int dreq; int dwe; int a; int b;} exp_t;

  typedef struct {
    int cyc; int rf; int wb; int pcs; int pcwe; int irwe; int dreq; int dwe;
    int a; int b; int iop; int done;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level reference: cost and visible effects derived from the instruction class.
  function automatic exp_t model(input logic [6:0] o, input logic br, input int iw, input int dw);
    exp_t e;
    bit is_b, is_lw, is_sw, is_jal, is_jalr, is_r, is_auipc;
    is_b = (o == 7'b1100011); is_lw = (o == 7'b0000011); is_sw = (o == 7'b0100011);
    is_jal = (o == 7'b1101111); is_jalr = (o == 7'b1100111); is_r = (o == 7'b0110011);
    is_auipc = (o == 7'b0010111);
    e.cyc  = (is_b ? 3 : is_lw ? 5 : 4) + iw + ((is_lw || is_sw) ? dw : 0);
    e.rf   = (is_b || is_sw) ? 0 : 1;
    e.wb   = is_lw ? 1 : (is_jal || is_jalr) ? 2 : 0;
    e.pcs  = is_b ? int'(br) : is_jal ? 1 : is_jalr ? 2 : 0;
    e.dreq = (is_lw || is_sw) ? dw + 1 : 0;
    e.dwe  = is_sw ? 1 : 0;
    e.a    = (is_auipc || is_jal || is_b) ? 1 : 0;
    e.b    = (is_r || is_b) ? 0 : 1;
    return e;
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic b, input int iw, input int dw,
                           output res_t r);
    int icnt, dcnt;
    icnt = 0; dcnt = 0;
    r = '{default: 0};
    op = o; br_taken = b;
    for (int c = 0; c < 64 && r.done == 0; c++) begin
      @(negedge clk);
      imem_ack = imem_req && (icnt == iw);
      dmem_ack = dmem_req && (dcnt == dw);
      #1;
      r.cyc++;
      if (imem_req) icnt++;
      if (dmem_req) begin dcnt++; r.dreq++; if (dmem_we) r.dwe = 1; end
      if (ir_we) r.irwe++;
      if (rf_we) begin r.rf++; r.wb = int'(wb_sel); end
      if (state == EXEC) begin r.a = int'(alu_a_sel); r.b = int'(alu_b_sel); r.iop = int'(imm_op); end
      if (pc_we) begin r.pcwe++; r.pcs = int'(pc_sel); r.done = 1; end
    end
    @(posedge clk); #1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (r.done != 0) exp_instret = exp_instret + 1;
  endtask

  task automatic check_common(input string tag, input logic [6:0] o, input exp_t e, input res_t r);
    check({tag, ".retired"}, r.done, 1);
    check({tag, ".cycles"}, r.cyc, e.cyc);
    check({tag, ".rf_we"}, r.rf, e.rf);
    check({tag, ".wb_sel"}, r.wb, e.wb);
    check({tag, ".pc_sel"}, r.pcs, e.pcs);
    check({tag, ".pc_we_cnt"}, r.pcwe, 1);
    check({tag, ".ir_we_cnt"}, r.irwe, 1);
    check({tag, ".dmem_req_cyc"}, r.dreq, e.dreq);
    check({tag, ".dmem_we"}, r.dwe, e.dwe);
    check({tag, ".alu_a"}, r.a, e.a);
    check({tag, ".alu_b"}, r.b, e.b);
    check({tag, ".imm_op"}, r.iop, {25'd0, o});
    check({tag, ".instret"}, instret, exp_instret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    exp_instret = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t        tbl[11];
  logic [6:0]  legal_ops[9];
  res_t        r;
  exp_t        e;
  int          reqc, strobes, traps;

  initial begin
    tbl[0]  = '{7'b0010011, 1'b0, 0, 0, 4, 1, 0, 0, 0, 1};
    tbl[1]  = '{7'b0000011, 1'b0, 0, 3, 8, 1, 1, 0, 0, 1};
    tbl[2]  = '{7'b1100011, 1'b1, 0, 0, 3, 0, 0, 1, 1, 0};
    tbl[3]  = '{7'b1100011, 1'b0, 0, 0, 3, 0, 0, 0, 1, 0};
    tbl[4]  = '{7'b1101111, 1'b0, 2, 0, 6, 1, 2, 1, 1, 1};
    tbl[5]  = '{7'b1100111, 1'b0, 0, 0, 4, 1, 2, 2, 0, 1};
    tbl[6]  = '{7'b0100011, 1'b0, 1, 1, 6, 0, 0, 0, 0, 1};
    tbl[7]  = '{7'b0110111, 1'b0, 0, 0, 4, 1, 0, 0, 0, 1};
    tbl[8]  = '{7'b0010111, 1'b0, 3, 0, 7, 1, 0, 0, 1, 1};
    tbl[9]  = '{7'b0110011, 1'b1, 0, 0, 4, 1, 0, 0, 0, 0};
    tbl[10] = '{7'b0000011, 1'b0, 3, 0, 8, 1, 1, 0, 0, 1};
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    // Reset state, then first request right after rst_n is sampled high.
    do_reset();
    @(posedge clk); #1;
    check("rst.state", state, FETCH);
    check("rst.instret", instret, 0);
    check("rst.illegal", illegal, 0);
    check("rst.timeout", timeout, 0);
    check("rst.imm_op", imm_op, 0);
    check("rst.strobes", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel}, 0);
    check("rst.sels", {pc_sel, wb_sel}, 0);
    release_reset();
    check("rel.imem_req", imem_req, 1);

    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i].op, tbl[i].br, tbl[i].iw, tbl[i].dw, r);
      check($sformatf("tbl%0d.cycles", i), r.cyc, tbl[i].cyc);
      check($sformatf("tbl%0d.rf_we", i), r.rf, tbl[i].rf);
      check($sformatf("tbl%0d.wb_sel", i), r.wb, tbl[i].wb);
      check($sformatf("tbl%0d.pc_sel", i), r.pcs, tbl[i].pcs);
      check($sformatf("tbl%0d.alu_a", i), r.a, tbl[i].a);
      check($sformatf("tbl%0d.alu_b", i), r.b, tbl[i].b);
      e = model(tbl[i].op, tbl[i].br, tbl[i].iw, tbl[i].dw);
      check_common($sformatf("tbl%0d", i), tbl[i].op, e, r);
    end

    for (int i = 0; i < 40; i++) begin
      logic [6:0] o;
      logic       b;
      int         iw, dw;
      o  = legal_ops[$urandom_range(0, 8)];
      b  = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      run_instr(o, b, iw, dw, r);
      e = model(o, b, iw, dw);
      check_common($sformatf("rnd%0d", i), o, e, r);
    end
    check("rnd.no_timeout", timeout, 0);

    // Fetch never acked: traps after exactly 4 request cycles.
    do_reset();
    release_reset();
    op = 7'b0010011;
    reqc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (state == TRAP) break;
      if (imem_req) reqc++;
    end
    check("to.req_cycles", reqc, 4);
    check("to.timeout", timeout, 1);
    check("to.state", state, TRAP);
    do_reset();
    check("to.rst_clear", timeout, 0);
    release_reset();
    run_instr(7'b0010011, 1'b0, 3, 0, r);
    check("to.ack4_done", r.done, 1);
    check("to.ack4_timeout", timeout, 0);
    check("to.ack4_state", state, FETCH);

    // Unknown opcode traps and the trap holds every strobe low.
    do_reset();
    release_reset();
    op = 7'b1111111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      imem_ack = imem_req;
      #1;
      if (state == TRAP) break;
    end
    check("ill.illegal", illegal, 1);
    check("ill.state", state, TRAP);
    check("ill.imm_op", imm_op, 7'h7f);
    strobes = 0; traps = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      br_taken = 1'($urandom_range(0, 1));
      #1;
      if (imem_req || dmem_req || dmem_we || ir_we || pc_we || rf_we) strobes++;
      if (state == TRAP) traps++;
    end
    check("ill.strobe_cycles", strobes, 0);
    check("ill.trap_cycles", traps, 20);
    check("ill.instret", instret, 0);
    do_reset();
    check("ill.rst_illegal", illegal, 0);
    check("ill.rst_state", state, FETCH);

    // Reset in the middle of a store's data wait; a late ack must be ignored.
    release_reset();
    run_instr(7'b0010011, 1'b0, 0, 0, r);
    check("mid.pre_instret", instret, 1);
    op = 7'b0100011;
    reqc = 0;
    for (int c = 0; c < 12 && reqc < 2; c++) begin
      @(negedge clk);
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) reqc++;
    end
    check("mid.in_mem", reqc, 2);
    do_reset();
    check("mid.dmem_req", dmem_req, 0);
    check("mid.state", state, FETCH);
    check("mid.instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    check("mid.late_state", state, FETCH);
    check("mid.late_dreq", dmem_req, 0);
    @(posedge clk); #1;
    check("mid.late_state2", state, FETCH);
    check("mid.late_instret", instret, 0);
    check("mid.late_timeout", timeout, 0);
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
